// File: rtl/ram_1p_fifo_ctrl_if.sv
// Push, pop and single-port RAM signal bundle for ram_1p_fifo_ctrl.
// slave = FIFO controller side, master = producer/consumer/RAM side.
interface ram_1p_fifo_ctrl_if #(
   parameter int Width = 32,
   parameter int Depth = 64
);
   localparam int Aw = $clog2(Depth);

   logic             push_valid_i;
   logic             push_ready_o;
   logic [Width-1:0] push_data_i;

   logic             pop_valid_o;
   logic             pop_ready_i;
   logic [Width-1:0] pop_data_o;

   logic             ram_req_o;
   logic             ram_write_o;
   logic [Aw-1:0]    ram_addr_o;
   logic [Width-1:0] ram_wdata_o;
   logic [Width-1:0] ram_wmask_o;
   logic [Width-1:0] ram_rdata_i;

   modport slave (
      input  push_valid_i, push_data_i, pop_ready_i, ram_rdata_i,
      output push_ready_o, pop_valid_o, pop_data_o,
      output ram_req_o, ram_write_o, ram_addr_o, ram_wdata_o, ram_wmask_o
   );

   modport master (
      output push_valid_i, push_data_i, pop_ready_i, ram_rdata_i,
      input  push_ready_o, pop_valid_o, pop_data_o,
      input  ram_req_o, ram_write_o, ram_addr_o, ram_wdata_o, ram_wmask_o
   );
endinterface

// File: rtl/ram_1p_fifo_ctrl.sv
// FIFO controller over a single-port RAM with a 2-entry registered output buffer.
// Optional watermark output compiled in with `define I3C_RAM_FIFO_THLD_EN.
module ram_1p_fifo_ctrl #(
   parameter int  Width = 32,
   parameter int  Depth = 64,
   localparam int Aw    = $clog2(Depth)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          clr_i,
   ram_1p_fifo_ctrl_if.slave bus,
   output logic [Aw+1:0] depth_o,
   output logic          full_o,
   output logic          empty_o,
   input  logic [Aw+1:0] thld_i,
   output logic          thld_trig_o
);
   localparam logic [Aw:0] DepthC = (Aw+1)'(Depth);

   logic [Aw-1:0]    r_wr_ptr;
   logic [Aw-1:0]    r_rd_ptr;
   logic [Aw:0]      r_ram_count;
   logic             r_rd_pending;
   logic             r_rd_prio;
   logic             r_ob_head;
   logic [1:0]       r_ob_count;
   logic [Width-1:0] r_ob [2];

   logic       w_block;
   logic       w_pop_valid;
   logic       w_pop;
   logic       w_push_ready;
   logic       w_push;
   logic [2:0] w_ob_need;
   logic       w_rd_elig;
   logic       w_rd_issue;
   logic       w_ob_tail;

   // Reset and flush both freeze every transfer in the cycle they are high.
   assign w_block     = rst_i | clr_i;
   assign w_pop_valid = (r_ob_count != 2'd0);
   assign w_pop       = w_pop_valid & bus.pop_ready_i & ~w_block;

   // Entries already held or in flight toward the OB, net of this cycle's pop.
   assign w_ob_need = {1'b0, r_ob_count} + {2'b0, r_rd_pending};
   assign w_rd_elig = (r_ram_count != '0) && (w_ob_need < (3'd2 + {2'b0, w_pop}));

   assign w_push_ready = ~w_block & (r_ram_count < DepthC) & ~(r_rd_prio & w_rd_elig);
   assign w_push       = bus.push_valid_i & w_push_ready;
   assign w_rd_issue   = w_rd_elig & ~w_push & ~w_block;

   // OB holds at most one entry whenever a capture lands, so tail is head+count.
   assign w_ob_tail = r_ob_head ^ r_ob_count[0];

   assign bus.push_ready_o = w_push_ready;
   assign bus.pop_valid_o  = w_pop_valid;
   assign bus.pop_data_o   = r_ob[r_ob_head];

   assign bus.ram_req_o   = w_push | w_rd_issue;
   assign bus.ram_write_o = w_push;
   assign bus.ram_addr_o  = w_push ? r_wr_ptr : r_rd_ptr;
   assign bus.ram_wdata_o = bus.push_data_i;
   assign bus.ram_wmask_o = w_push ? {Width{1'b1}} : {Width{1'b0}};

   assign depth_o = {1'b0, r_ram_count} + (Aw+2)'(r_rd_pending) + (Aw+2)'(r_ob_count);
   assign empty_o = (depth_o == '0);
   assign full_o  = (r_ram_count == DepthC);

   always_ff @(posedge clk_i) begin
      if (w_block) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_ram_count  <= '0;
         r_rd_pending <= 1'b0;
         r_rd_prio    <= 1'b0;
         r_ob_head    <= 1'b0;
         r_ob_count   <= 2'd0;
         if (rst_i) begin
            r_ob <= '{default: '0};
         end
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + Aw'(1);
         end
         if (w_rd_issue) begin
            r_rd_ptr <= r_rd_ptr + Aw'(1);
         end

         if (w_push) begin
            r_ram_count <= r_ram_count + (Aw+1)'(1);
         end else if (w_rd_issue) begin
            r_ram_count <= r_ram_count - (Aw+1)'(1);
         end

         r_rd_pending <= w_rd_issue;

         // A read that lost to a push wins the next contested cycle.
         if (w_rd_issue) begin
            r_rd_prio <= 1'b0;
         end else if (w_rd_elig && w_push) begin
            r_rd_prio <= 1'b1;
         end

         if (r_rd_pending) begin
            r_ob[w_ob_tail] <= bus.ram_rdata_i;
         end
         if (w_pop) begin
            r_ob_head <= ~r_ob_head;
         end
         r_ob_count <= r_ob_count + {1'b0, r_rd_pending} - {1'b0, w_pop};
      end
   end

`ifdef I3C_RAM_FIFO_THLD_EN
   logic r_thld_trig;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_thld_trig <= 1'b0;
      end else begin
         r_thld_trig <= (thld_i != '0) && (depth_o >= thld_i);
      end
   end

   assign thld_trig_o = r_thld_trig;
`else
   logic w_unused_thld;

   assign w_unused_thld = ^thld_i;
   assign thld_trig_o   = 1'b0;
`endif

endmodule

// File: tb/tb_ram_1p_fifo_ctrl.sv
// Randomized bench for ram_1p_fifo_ctrl: queue-based occupancy/order model plus
// transaction-count RAM model, with literal checks for latency, full, flush and watermark.
module tb_ram_1p_fifo_ctrl;
   localparam int W  = 32;
   localparam int D  = 64;
   localparam int AW = $clog2(D);

   logic          clk = 1'b0;
   logic          rst;
   logic          clr;
   logic [AW+1:0] depth_o;
   logic          full_o;
   logic          empty_o;
   logic [AW+1:0] thld;
   logic          thld_trig_o;

   int total = 0;
   int bad   = 0;

   ram_1p_fifo_ctrl_if #(.Width(W), .Depth(D)) bus ();

   ram_1p_fifo_ctrl #(.Width(W), .Depth(D)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .clr_i       (clr),
      .bus         (bus),
      .depth_o     (depth_o),
      .full_o      (full_o),
      .empty_o     (empty_o),
      .thld_i      (thld),
      .thld_trig_o (thld_trig_o)
   );

   always #5 clk = ~clk;

   // Single-port RAM: read data appears the cycle after the request.
   logic [W-1:0] mem [D];
   always @(posedge clk) begin
      if (bus.ram_req_o) begin
         if (bus.ram_write_o) mem[bus.ram_addr_o] <= bus.ram_wdata_o;
         else                 bus.ram_rdata_i     <= mem[bus.ram_addr_o];
      end
   end

   task automatic chk(input string nm, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: every word accepted and not yet popped, in order.
   logic [W-1:0] mq[$];
   int  ram_cnt, out_cnt, pend, wr_p, rd_p, starve, pops_cnt, wrap_seen, last_waddr;
   bit  trig_exp, push_x, pop_x, rd_x, elig;

   always @(negedge clk) begin
      if (rst) begin
         chk("rst_push_ready", bus.push_ready_o, 0);
         chk("rst_ram_req", bus.ram_req_o, 0);
         mq.delete();
         ram_cnt = 0; out_cnt = 0; pend = 0; wr_p = 0; rd_p = 0; starve = 0;
         trig_exp = 0;
      end else begin
         chk("depth", depth_o, mq.size());
         chk("empty", empty_o, mq.size() == 0);
         chk("full", full_o, ram_cnt == D);
         chk("pop_valid", bus.pop_valid_o, (out_cnt - pend) > 0);
         if (bus.pop_valid_o && mq.size() > 0) chk("pop_data", bus.pop_data_o, mq[0]);
         chk("thld_trig", thld_trig_o, trig_exp);
`ifdef I3C_RAM_FIFO_THLD_EN
         trig_exp = (thld != 0) && (mq.size() >= int'(thld));
`else
         trig_exp = 0;
`endif
         push_x = bus.push_valid_i && bus.push_ready_o;
         pop_x  = bus.pop_valid_o && bus.pop_ready_i;
         rd_x   = bus.ram_req_o && !bus.ram_write_o;
         if (clr) begin
            chk("clr_push_ready", bus.push_ready_o, 0);
            chk("clr_ram_req", bus.ram_req_o, 0);
            mq.delete();
            ram_cnt = 0; out_cnt = 0; pend = 0; wr_p = 0; rd_p = 0; starve = 0;
         end else begin
            chk("ram_write", bus.ram_req_o && bus.ram_write_o, push_x);
            chk("cap_ovf", bus.push_ready_o && ram_cnt >= D, 0);
            if (push_x) begin
               chk("wr_addr", bus.ram_addr_o, wr_p);
               chk("wr_data", bus.ram_wdata_o, bus.push_data_i);
               chk("wr_mask", bus.ram_wmask_o, 32'hFFFF_FFFF);
               if (bus.ram_addr_o == 0 && last_waddr == D - 1) wrap_seen++;
               last_waddr = bus.ram_addr_o;
            end
            if (rd_x) chk("rd_addr", bus.ram_addr_o, rd_p);
            elig = ram_cnt > 0 && (out_cnt - int'(pop_x)) < 2;
            chk("rd_issue", rd_x, elig && !push_x);
            if (elig && !rd_x) starve++; else starve = 0;
            chk("rd_starve", starve > 1, 0);
            if (pop_x) begin
               void'(mq.pop_front());
               out_cnt--;
               pops_cnt++;
            end
            if (push_x) begin
               mq.push_back(bus.push_data_i);
               ram_cnt++;
               wr_p = (wr_p + 1) % D;
            end
            if (rd_x) begin
               ram_cnt--;
               out_cnt++;
               rd_p = (rd_p + 1) % D;
            end
            pend = rd_x;
         end
      end
   end

   task automatic push_n(input int n, input bit popr);
      int got = 0;
      @(posedge clk); #1;
      bus.pop_ready_i = popr;
      for (int c = 0; c < 4000 && got < n; c++) begin
         bus.push_valid_i = 1'b1;
         bus.push_data_i  = $urandom;
         @(negedge clk);
         if (bus.push_ready_o) got++;
         @(posedge clk); #1;
      end
      bus.push_valid_i = 1'b0;
      chk("push_count", got, n);
   endtask

   task automatic drain();
      int c = 0;
      @(posedge clk); #1;
      bus.push_valid_i = 1'b0;
      bus.pop_ready_i  = 1'b1;
      @(negedge clk);
      while (!empty_o && c < 1000) begin
         @(negedge clk);
         c++;
      end
      chk("drain_done", empty_o, 1);
      @(posedge clk); #1;
      bus.pop_ready_i = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int pops_base;
      rst = 1'b1; clr = 1'b0; thld = 8'd8;
      bus.push_valid_i = 1'b0; bus.pop_ready_i = 1'b0; bus.push_data_i = '0;
      pops_cnt = 0; wrap_seen = 0; last_waddr = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      @(negedge clk);
      chk("reset_pop_valid", bus.pop_valid_o, 0);
      chk("reset_depth", depth_o, 0);
      chk("reset_empty", empty_o, 1);
      chk("reset_full", full_o, 0);
      chk("reset_ram_req", bus.ram_req_o, 0);
      chk("reset_push_ready", bus.push_ready_o, 1);
      chk("reset_thld_trig", thld_trig_o, 0);

      // First-word latency: push at N, read at N+1, pop_valid at N+3.
      @(posedge clk); #1;
      bus.push_valid_i = 1'b1; bus.push_data_i = 32'hA5A5_0001; bus.pop_ready_i = 1'b1;
      @(posedge clk); #1;
      bus.push_valid_i = 1'b0;
      @(negedge clk);
      chk("lat_n1_read", bus.ram_req_o && !bus.ram_write_o, 1);
      chk("lat_n1_pop_valid", bus.pop_valid_o, 0);
      @(negedge clk);
      chk("lat_n2_pop_valid", bus.pop_valid_o, 0);
      @(negedge clk);
      chk("lat_n3_pop_valid", bus.pop_valid_o, 1);
      chk("lat_n3_pop_data", bus.pop_data_o, 32'hA5A5_0001);
      @(negedge clk);
      chk("lat_depth_after", depth_o, 0);

      // Fill to capacity Depth+2 with the consumer stalled.
      @(posedge clk); #1;
      bus.pop_ready_i = 1'b0;
      push_n(66, 1'b0);
      @(negedge clk);
      chk("fill_push_ready", bus.push_ready_o, 0);
      chk("fill_full", full_o, 1);
      chk("fill_depth", depth_o, 66);
      drain();

      // Continuous push and pop.
      @(posedge clk); #1;
      bus.push_valid_i = 1'b1; bus.pop_ready_i = 1'b1;
      repeat (200) begin
         bus.push_data_i = $urandom;
         @(posedge clk); #1;
      end
      // Random traffic with occasional flushes, then a producer-heavy burst.
      repeat (400) begin
         bus.push_valid_i = ($urandom_range(0, 3) != 0);
         bus.pop_ready_i  = ($urandom_range(0, 3) != 0);
         bus.push_data_i  = $urandom;
         clr = ($urandom_range(0, 49) == 0);
         @(posedge clk); #1;
      end
      repeat (200) begin
         bus.push_valid_i = ($urandom_range(0, 7) != 0);
         bus.pop_ready_i  = ($urandom_range(0, 7) == 0);
         bus.push_data_i  = $urandom;
         clr = 1'b0;
         @(posedge clk); #1;
      end
      clr = 1'b0;
      drain();

      // Pointer wrap: 3*Depth words streamed through.
      pops_base = pops_cnt;
      wrap_seen = 0;
      push_n(3 * D, 1'b1);
      drain();
      chk("wrap_pops", pops_cnt - pops_base, 3 * D);
      chk("wrap_addr_seen", wrap_seen >= 2, 1);

      // Flush while a read is in flight with depth 10.
      push_n(11, 1'b0);
      repeat (5) @(posedge clk);
      #1 bus.pop_ready_i = 1'b1;
      @(negedge clk);
      chk("clr_setup_read", bus.ram_req_o && !bus.ram_write_o, 1);
      @(posedge clk); #1;
      bus.pop_ready_i = 1'b0; clr = 1'b1;
      @(negedge clk);
      chk("clr_depth10", depth_o, 10);
      @(posedge clk); #1;
      clr = 1'b0;
      @(negedge clk);
      chk("clr_depth0", depth_o, 0);
      chk("clr_pop_valid", bus.pop_valid_o, 0);
      @(posedge clk); #1;
      bus.push_valid_i = 1'b1; bus.push_data_i = 32'h1234_5678; bus.pop_ready_i = 1'b0;
      @(posedge clk); #1;
      bus.push_valid_i = 1'b0;
      repeat (3) @(negedge clk);
      chk("clr_fresh_valid", bus.pop_valid_o, 1);
      chk("clr_fresh_data", bus.pop_data_o, 32'h1234_5678);
      drain();

      // Watermark at 8.
      push_n(8, 1'b0);
      @(negedge clk);
`ifdef I3C_RAM_FIFO_THLD_EN
      chk("thld_at8_same", thld_trig_o, 0);
      @(negedge clk);
      chk("thld_at8_next", thld_trig_o, 1);
      @(posedge clk); #1;
      bus.pop_ready_i = 1'b1;
      @(negedge clk);
      chk("thld_pop_valid", bus.pop_valid_o, 1);
      @(posedge clk); #1;
      bus.pop_ready_i = 1'b0;
      @(negedge clk);
      chk("thld_at7_same", thld_trig_o, 1);
      @(negedge clk);
      chk("thld_at7_next", thld_trig_o, 0);
`else
      chk("thld_tied_low", thld_trig_o, 0);
      @(negedge clk);
      chk("thld_tied_low2", thld_trig_o, 0);
`endif
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/ram_1p_fifo_ctrl.md
RAM_1P_FIFO_CTRL -- requirements
Module: ram_1p_fifo_ctrl

Interface
REQ-001 SHALL have parameter Width, default 32, data width in bits.
REQ-002 SHALL have parameter Depth, default 64, RAM entries; power of two, >=4; Aw=$clog2(Depth) derived.
REQ-003 SHALL have ports: clk_i  in  1  clock; rst_i  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports: clr_i  in  1  sync flush; push_valid_i  in  1; push_ready_o  out  1; push_data_i  in  Width.
REQ-005 SHALL have ports: pop_valid_o  out  1; pop_ready_i  in  1; pop_data_o  out  Width.
REQ-006 SHALL have ports: depth_o  out  Aw+2  total occupancy; full_o  out  1; empty_o  out  1.
REQ-007 SHALL have RAM-side ports: ram_req_o  out  1; ram_write_o  out  1; ram_addr_o  out  Aw; ram_wdata_o  out  Width; ram_wmask_o  out  Width; ram_rdata_i  in  Width (valid the cycle after a read request).
REQ-008 SHALL have ports: thld_i  in  Aw+2  watermark; thld_trig_o  out  1.

Function
REQ-009 SHALL implement a FIFO of capacity Depth+2: RAM store plus a 2-entry registered output buffer (OB) driving pop_data_o.
REQ-010 SHALL transfer on push when push_valid_i & push_ready_o, and on pop when pop_valid_o & pop_ready_i.
REQ-011 SHALL, in a push-transfer cycle, drive ram_req_o=1, ram_write_o=1, ram_addr_o=wr_ptr, ram_wdata_o=push_data_i, ram_wmask_o all ones; wr_ptr increments modulo Depth.
REQ-012 SHALL define read-eligible: ram_count>0 and (ob_count + rd_pending - pop_transfer) < 2.
REQ-013 SHALL, in a read-issue cycle, drive ram_req_o=1, ram_write_o=0, ram_addr_o=rd_ptr; rd_ptr increments modulo Depth; rd_pending set for the next cycle.
REQ-014 SHALL capture ram_rdata_i into OB tail in every rd_pending cycle; never drop it, even with a simultaneous pop.
REQ-015 SHALL never issue write and read in the same cycle (single port); one ram_req_o per cycle max.
REQ-016 SHALL arbitrate with flag rd_prio: push_ready_o = (ram_count<Depth) & !(rd_prio & read-eligible); read issued when read-eligible and no push transfer.
REQ-017 SHALL set rd_prio when read-eligible but a push transferred; clear it when a read issues.
REQ-018 SHALL drive pop_valid_o=(ob_count>0), pop_data_o=OB head; OB pop and capture in same cycle legal.
REQ-019 SHALL drive depth_o = ram_count + rd_pending + ob_count; empty_o=(depth_o==0); full_o=(ram_count==Depth).
REQ-020 SHALL give first-word latency 3 cycles: push at N, read at N+1, pop_valid_o high at N+3 (idle pop side).
REQ-021 SHALL sustain one pop per cycle when no push competes, and one push per cycle when read-ineligible.
REQ-022 SHALL, on clr_i, zero pointers, ram_count, rd_pending, ob_count, rd_prio; clr_i overrides push/pop that cycle; push_ready_o=0 and ram_req_o=0 while clr_i high.
REQ-023 SHALL discard in-flight read data when clr_i is asserted in its rd_pending cycle.

Reset
REQ-024 SHALL on rst_i reset all state as clr_i does, state after the reset edge: pop_valid_o=0, depth_o=0, empty_o=1, full_o=0, ram_req_o=0, push_ready_o=1, thld_trig_o=0.
REQ-025 SHALL force push_ready_o=0 and ram_req_o=0 while rst_i is high; reset mid-transfer loses all contents.

Configuration
REQ-026 SHALL compile watermark logic only when I3C_RAM_FIFO_THLD_EN is defined: thld_trig_o registered, =1 cycle after depth_o>=thld_i with thld_i!=0.
REQ-027 SHALL, without I3C_RAM_FIFO_THLD_EN, tie thld_trig_o=0 and leave thld_i unused.

Verification
REQ-028 SHALL verify: single push 0xA5A5_0001 into empty FIFO, pop_ready_i=1 -> pop_valid_o at N+3 with 0xA5A5_0001, depth_o back to 0.
REQ-029 SHALL verify: Depth=64, 66 pushes with pop_ready_i=0 -> push_ready_o=0 after 66th, full_o=1, depth_o=66; pops return data in order.
REQ-030 SHALL verify: continuous push and pop for 200 cycles -> never two ram_req_o types in one cycle, no read starves >1 cycle, data order preserved.
REQ-031 SHALL verify: pointer wrap, 3*Depth sequential pushes/pops -> all 192 words in order, ram_addr_o wraps 63->0.
REQ-032 SHALL verify: clr_i during rd_pending with depth_o=10 -> next cycle depth_o=0, pop_valid_o=0, stale rdata not popped.
REQ-033 SHALL verify: with I3C_RAM_FIFO_THLD_EN, thld_i=8 -> thld_trig_o rises one cycle after depth_o reaches 8, falls one cycle after it drops to 7.
